// File: rtl/bridge_pkg.sv
// bridge_pkg: FSM state types, AXI encodings and default IDs shared by the
// sram-to-AXI bridge and its write-channel engine.
package bridge_pkg;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_AW_W, W_B} wr_state_t;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_B = 3'd0;
    localparam logic [2:0] AXI_SIZE_H = 3'd1;
    localparam logic [2:0] AXI_SIZE_W = 3'd2;
    localparam logic [3:0] ID_INST_DEF = 4'd0;
    localparam logic [3:0] ID_DATA_DEF = 4'd1;
    // Irregular strobe patterns fall back to a full-word transfer; wstrb still masks the lanes.
    function automatic logic [2:0] sizeFromSel(input logic [3:0] sel);
        return (sel == 4'b1111) ? AXI_SIZE_W :
               (sel == 4'b0011 || sel == 4'b1100) ? AXI_SIZE_H :
               $onehot(sel) ? AXI_SIZE_B : AXI_SIZE_W;
    endfunction
endpackage

// File: rtl/sram_axi_bridge_if.sv
// sram_axi_bridge_if: AXI3 read/write bus between the bridge (master) and
// the memory system (slave); single beats only, so no bresp/rresp is carried.
interface sram_axi_bridge_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic [3:0] arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic arvalid, arready;
    logic [3:0] rid;
    logic [DATA_W-1:0] rdata;
    logic rlast, rvalid, rready;
    logic [3:0] awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic awvalid, awready;
    logic [DATA_W-1:0] wdata;
    logic [3:0] wstrb;
    logic wlast, wvalid, wready;
    logic bvalid, bready;
    modport master(
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rlast, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bvalid, output bready
    );
    modport slave(
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rlast, rvalid, input rready,
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bvalid, input bready
    );
endinterface

// File: rtl/sram_axi_wr.sv
// sram_axi_wr: single-outstanding store engine; issues AW and W together,
// retires each on its own handshake, then waits for the B response.
module sram_axi_wr
    import bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdataIn,
    input  logic [3:0]        sel,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready,
    output logic              ok,
    output logic              idle
);
    wr_state_t state, next;
    logic aw_done, w_done;
    logic awHs, wHs;
    assign awHs = awvalid & awready;
    assign wHs = wvalid & wready;
    assign awvalid = (state == W_AW_W) & ~aw_done;
    assign wvalid = (state == W_AW_W) & ~w_done;
    assign bready = state == W_B;
    assign idle = state == W_IDLE;
    assign awsize = sizeFromSel(wstrb);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= W_IDLE;
        else state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            W_IDLE: next = start ? W_AW_W : W_IDLE;
            W_AW_W: next = ((aw_done | awHs) & (w_done | wHs)) ? W_B : W_AW_W;
            W_B: next = bvalid ? W_IDLE : W_B;
            default: next = W_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            awaddr <= '0;
            wdata <= '0;
            wstrb <= '0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
            ok <= 1'b0;
        end else begin
            ok <= (state == W_B) & bvalid;
            if (state == W_IDLE && start) begin
                awaddr <= addr;
                wdata <= wdataIn;
                wstrb <= sel;
                aw_done <= 1'b0;
                w_done <= 1'b0;
            end else begin
                if (awHs) aw_done <= 1'b1;
                if (wHs) w_done <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: folds the core's fetch and data sram ports onto one AXI3
// master; arbitrates the read channel and stalls the core until each access completes.
module sram_axi_bridge
    import bridge_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter logic [3:0] ID_INST = ID_INST_DEF,
    parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_sel,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ok,
    output logic              stall,
    sram_axi_bridge_if.master axi
);
    rd_state_t rdState, rdNext;
    logic [ADDR_W-1:0] arAddr;
    logic [3:0] arId;
    logic rdDataOk, wrOk, wrIdle, wrStart;
    logic takeData, takeInst, rdAccept, rdDone;
    // Loads wait for an idle write engine so a load never overtakes an earlier store.
    // A port whose ok is pulsing is still holding req for the finished access, so it is not re-taken.
    assign takeData = data_req & ~data_wr & ~data_ok & wrIdle;
    assign takeInst = inst_req & ~inst_ok & ~takeData;
    assign rdAccept = (rdState == R_IDLE) & (takeData | takeInst);
    assign rdDone = (rdState == R_R) & axi.rvalid;
    assign wrStart = data_req & data_wr & ~data_ok;
    assign data_ok = rdDataOk | wrOk;
    assign stall = (inst_req & ~inst_ok) | (data_req & ~data_ok);
    assign axi.arid = arId;
    assign axi.araddr = arAddr;
    assign axi.arlen = 4'd0;
    assign axi.arsize = AXI_SIZE_W;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arvalid = rdState == R_AR;
    assign axi.rready = rdState == R_R;
    assign axi.awid = ID_DATA;
    assign axi.awlen = 4'd0;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.wlast = 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdState <= R_IDLE;
        else rdState <= rdNext;
    end
    always_comb begin
        rdNext = rdState;
        case (rdState)
            R_IDLE: rdNext = rdAccept ? R_AR : R_IDLE;
            R_AR: rdNext = axi.arready ? R_R : R_AR;
            R_R: rdNext = axi.rvalid ? R_IDLE : R_R;
            default: rdNext = R_IDLE;
        endcase
    end
    // Responses are routed by the ID latched at issue, not by rid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arAddr <= '0;
            arId <= '0;
            inst_rdata <= '0;
            data_rdata <= '0;
            inst_ok <= 1'b0;
            rdDataOk <= 1'b0;
        end else begin
            inst_ok <= rdDone && arId != ID_DATA;
            rdDataOk <= rdDone && arId == ID_DATA;
            if (rdAccept) begin
                arAddr <= takeData ? data_addr : inst_addr;
                arId <= takeData ? ID_DATA : ID_INST;
            end
            if (rdDone && arId == ID_DATA) data_rdata <= axi.rdata;
            if (rdDone && arId != ID_DATA) inst_rdata <= axi.rdata;
        end
    end
    sram_axi_wr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr (
        .clk(clk), .rst(rst), .start(wrStart),
        .addr(data_addr), .wdataIn(data_wdata), .sel(data_sel),
        .awaddr(axi.awaddr), .awsize(axi.awsize), .awvalid(axi.awvalid), .awready(axi.awready),
        .wdata(axi.wdata), .wstrb(axi.wstrb), .wvalid(axi.wvalid), .wready(axi.wready),
        .bvalid(axi.bvalid), .bready(axi.bready), .ok(wrOk), .idle(wrIdle)
    );
    instReqHeld: assert property (@(posedge clk) disable iff (rst) inst_req & ~inst_ok |=> inst_req);
    dataReqHeld: assert property (@(posedge clk) disable iff (rst) data_req & ~data_ok |=> data_req);
    rIdMatch: assert property (@(posedge clk) disable iff (rst) axi.rvalid & axi.rready |-> axi.rid == arId && axi.rlast);
endmodule

// File: tb/tb_sram_axi_bridge.sv
// tb_sram_axi_bridge: directed vectors against a small AXI slave with
// programmable wait states; expected values are hand-computed constants.
module tb_sram_axi_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic inst_req = 1'b0, data_req = 1'b0, data_wr = 1'b0;
    logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
    logic [3:0] data_sel = '0;
    logic [31:0] inst_rdata, data_rdata;
    logic inst_ok, data_ok, stall;
    sram_axi_bridge_if axi();
    sram_axi_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
        .data_req(data_req), .data_wr(data_wr), .data_sel(data_sel), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ok(data_ok),
        .stall(stall), .axi(axi)
    );
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a == 32'hBFC00000) ? 32'h3C080001 : a ^ 32'hA5A5A5A5;
    endfunction
    int arDelay = 0, rDelay = 0, awDelay = 0, wDelay = 0, bDelay = 0;
    int arCnt, rCnt, awCnt, wCnt, bCnt;
    logic rPend, bPend, awGot, wGot;
    logic [31:0] rAddr, capAwaddr, capWdata;
    logic [3:0] rIdL, capWstrb;
    logic [2:0] capAwsize;
    logic [9:0] capAwMeta;
    logic capWlast;
    assign axi.arready = axi.arvalid && arCnt >= arDelay;
    assign axi.rvalid = rPend && rCnt >= rDelay;
    assign axi.rid = rIdL;
    assign axi.rdata = axi.rvalid ? memWord(rAddr) : 32'h0;
    assign axi.rlast = axi.rvalid;
    assign axi.awready = axi.awvalid && awCnt >= awDelay;
    assign axi.wready = axi.wvalid && wCnt >= wDelay;
    assign axi.bvalid = bPend && bCnt >= bDelay;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            arCnt <= 0; rCnt <= 0; awCnt <= 0; wCnt <= 0; bCnt <= 0;
            rPend <= 0; bPend <= 0; awGot <= 0; wGot <= 0; rAddr <= 0; rIdL <= 0;
            capAwaddr <= 0; capWdata <= 0; capWstrb <= 0; capAwsize <= 0; capAwMeta <= 0; capWlast <= 0;
        end else begin
            arCnt <= (axi.arvalid && !axi.arready) ? arCnt + 1 : 0;
            awCnt <= (axi.awvalid && !axi.awready) ? awCnt + 1 : 0;
            wCnt <= (axi.wvalid && !axi.wready) ? wCnt + 1 : 0;
            if (axi.arvalid && axi.arready) begin
                rPend <= 1; rCnt <= 0; rAddr <= axi.araddr; rIdL <= axi.arid;
            end else if (rPend) begin
                if (axi.rvalid && axi.rready) rPend <= 0;
                else rCnt <= rCnt + 1;
            end
            if (axi.awvalid && axi.awready) begin
                awGot <= 1; capAwaddr <= axi.awaddr; capAwsize <= axi.awsize;
                capAwMeta <= {axi.awid, axi.awlen, axi.awburst};
            end
            if (axi.wvalid && axi.wready) begin
                wGot <= 1; capWdata <= axi.wdata; capWstrb <= axi.wstrb; capWlast <= axi.wlast;
            end
            if (bPend) begin
                if (axi.bvalid && axi.bready) bPend <= 0;
                else bCnt <= bCnt + 1;
            end else if ((awGot || (axi.awvalid && axi.awready)) && (wGot || (axi.wvalid && axi.wready))) begin
                bPend <= 1; bCnt <= 0; awGot <= 0; wGot <= 0;
            end
        end
    end
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int arN = 0, instOkN = 0, dataOkN = 0, bHsCyc = 0, stallN = 0, rreadyN = 0, awvN = 0, wvN = 0;
    int arLogCyc [16];
    logic [3:0] arLogId [16];
    always @(negedge clk) begin
        if (axi.arvalid && axi.arready && arN < 16) begin
            arLogCyc[arN] = cyc; arLogId[arN] = axi.arid; arN++;
        end
        if (inst_ok) instOkN++;
        if (data_ok) dataOkN++;
        if (stall) stallN++;
        if (axi.rready) rreadyN++;
        if (axi.awvalid) awvN++;
        if (axi.wvalid) wvN++;
        if (axi.bvalid && axi.bready) bHsCyc = cyc;
    end
    int checks = 0, errors = 0, runBase = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // Plays the core: holds each req until its ok, drops it the cycle after; latencies count from cycle 0.
    task automatic runPorts(output int iLat, output int dLat, output logic [31:0] gI,
                            output logic [31:0] gD, output logic sEnd);
        int k;
        iLat = 99; dLat = 99; gI = 0; gD = 0; sEnd = 1; k = 0;
        runBase = cyc;
        while ((inst_req || data_req) && k < 60) begin
            @(negedge clk);
            if (data_req && data_ok) begin dLat = k; gD = data_rdata; end
            if (inst_req && inst_ok) begin iLat = k; gI = inst_rdata; end
            sEnd = stall;
            tick;
            if (dLat != 99) data_req = 0;
            if (iLat != 99) inst_req = 0;
            k++;
        end
        if (inst_req || data_req) begin
            check("run_timeout", k, 0);
            inst_req = 0; data_req = 0;
        end
    endtask
    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        tick;
        data_req = 1; data_wr = 1; data_addr = a; data_wdata = d; data_sel = s;
    endtask
    logic [3:0] selTab [4] = '{4'b1111, 4'b0011, 4'b1000, 4'b1010};
    logic [2:0] sizeTab [4] = '{3'd2, 3'd1, 3'd0, 3'd2};
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int iLat, dLat, n0, s0, r0, a0, w0, k0, base;
        logic [31:0] gI, gD;
        logic sEnd;
        repeat (3) tick;
        check("rst_ctrl", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, inst_ok, data_ok, stall}, 0);
        check("rst_rdata", inst_rdata | data_rdata, 0);
        rst = 0;
        // single fetch, zero-wait slave
        tick;
        inst_req = 1; inst_addr = 32'hBFC00000; n0 = arN;
        runPorts(iLat, dLat, gI, gD, sEnd);
        check("fetch_lat", iLat, 3);
        check("fetch_data", gI, 32'h3C080001);
        check("fetch_arid", arLogId[n0], 0);
        check("fetch_ar_cyc", arLogCyc[n0] - runBase, 1);
        check("fetch_stall_at_ok", sEnd, 0);
        check("ar_const", {axi.arlen, axi.arsize, axi.arburst}, {4'd0, 3'd2, 2'b01});
        // simultaneous fetch and load: load wins, fetch follows data_ok
        tick;
        inst_req = 1; inst_addr = 32'hBFC00000;
        data_req = 1; data_wr = 0; data_addr = 32'h80001000; n0 = arN;
        runPorts(iLat, dLat, gI, gD, sEnd);
        check("both_data_lat", dLat, 3);
        check("both_inst_lat", iLat, 6);
        check("both_data", gD, 32'h25A5B5A5);
        check("both_inst", gI, 32'h3C080001);
        check("both_ar0_id", arLogId[n0], 1);
        check("both_ar1_id", arLogId[n0 + 1], 0);
        check("both_ar1_cyc", arLogCyc[n0 + 1] - runBase, 4);
        // byte store with awready delayed 3 cycles
        awDelay = 3;
        store(32'h80000006, 32'h00AB0000, 4'b0100);
        a0 = awvN; w0 = wvN; k0 = dataOkN;
        runPorts(iLat, dLat, gI, gD, sEnd);
        check("st_lat", dLat, 6);
        check("st_awsize", capAwsize, 0);
        check("st_wstrb", capWstrb, 4'b0100);
        check("st_awaddr", capAwaddr, 32'h80000006);
        check("st_wdata", capWdata, 32'h00AB0000);
        check("st_wlast", capWlast, 1);
        check("st_aw_meta", capAwMeta, {4'd1, 4'd0, 2'b01});
        check("st_wvalid_cycles", wvN - w0, 1);
        check("st_awvalid_cycles", awvN - a0, 4);
        repeat (3) tick;
        check("st_ok_pulses", dataOkN - k0, 1);
        awDelay = 0;
        // store then load to the same address
        store(32'h80000010, 32'h12345678, 4'b1100);
        runPorts(iLat, dLat, gI, gD, sEnd);
        check("raw_st_lat", dLat, 3);
        check("raw_st_awsize", capAwsize, 1);
        data_req = 1; data_wr = 0; n0 = arN;
        runPorts(iLat, dLat, gI, gD, sEnd);
        check("raw_ld_lat", dLat, 3);
        check("raw_ld_data", gD, 32'h25A5A5B5);
        check("raw_ar_after_b", arLogCyc[n0] - bHsCyc, 3);
        // awsize decode across strobe patterns
        for (int i = 0; i < 4; i++) begin
            store(32'h80000020, 32'hCAFEF00D, selTab[i]);
            runPorts(iLat, dLat, gI, gD, sEnd);
            check("tab_awsize", capAwsize, sizeTab[i]);
            check("tab_wstrb", capWstrb, selTab[i]);
        end
        // rvalid held off 5 cycles
        rDelay = 5;
        tick;
        inst_req = 1; inst_addr = 32'h00000100;
        s0 = stallN; r0 = rreadyN; k0 = instOkN;
        runPorts(iLat, dLat, gI, gD, sEnd);
        check("slow_lat", iLat, 8);
        check("slow_data", gI, 32'hA5A5A4A5);
        check("slow_stall_cycles", stallN - s0, 8);
        check("slow_rready_cycles", rreadyN - r0, 6);
        repeat (3) tick;
        check("slow_ok_pulses", instOkN - k0, 1);
        // reset while waiting in R_R
        tick;
        inst_req = 1; inst_addr = 32'h00000200;
        repeat (3) @(negedge clk);
        check("rready_before_rst", axi.rready, 1);
        @(posedge clk);
        #3;
        rst = 1; inst_req = 0;
        #1;
        check("midrst_ctrl", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, inst_ok, data_ok, stall}, 0);
        check("midrst_inst_rdata", inst_rdata, 0);
        check("midrst_data_rdata", data_rdata, 0);
        repeat (2) tick;
        rst = 0; rDelay = 0;
        tick;
        inst_req = 1; inst_addr = 32'hBFC00000;
        runPorts(iLat, dLat, gI, gD, sEnd);
        check("post_rst_lat", iLat, 3);
        check("post_rst_data", gI, 32'h3C080001);
        base = cyc;
        repeat (2) tick;
        check("idle_cycles", cyc - base, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
